// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if -- byte-level request interface between the sequencer
// (master) and lcd_display (slave).
//   if_data  : byte to send (only the upper nibble is used when if_8bit=0)
//   if_rs    : 0 command, 1 character
//   if_delay : wait cycles lcd_display inserts after the byte
//   if_write : write request, held until the slave drops if_ready
//   if_ready : slave accepting requests
//   if_8bit  : 1 = send both nibbles
interface lcd_sequencer_if;
  logic [7:0]  if_data;
  logic        if_rs;
  logic [31:0] if_delay;
  logic        if_write;
  logic        if_ready;
  logic        if_8bit;

  modport master (output if_data, if_rs, if_delay, if_write, if_8bit, input if_ready);
  modport slave  (input if_data, if_rs, if_delay, if_write, if_8bit, output if_ready);
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer -- runs the HD44780 4-bit init sequence, then copies a 2x16
// character buffer to the panel through the lcd_display byte interface.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en/addr/data   host buffer write port (0-15 line 1, 16-31 line 2)
//   refresh           pulse: request a full display pass (ignored while busy)
//   init_done, busy   status
//   lcd               lcd_sequencer_if master modport
// Optional feature: define LCD_SEQ_AUTO_REFRESH_EN to start a pass after
// REFRESH_GAP idle cycles even without writes or refresh.
module lcd_sequencer #(
  parameter int unsigned DLY_PWRUP   = 205000,
  parameter int unsigned DLY_NIB     = 5000,
  parameter int unsigned DLY_CMD     = 2000,
  parameter int unsigned DLY_CLR     = 82000,
  parameter int unsigned REFRESH_GAP = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       init_done,
  output logic       busy,
  lcd_sequencer_if.master lcd
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_PASS} mode_e;
  typedef enum logic [1:0] {PH_ISSUE, PH_ACCEPT, PH_DONE} phase_e;

  mode_e       mode_q;
  phase_e      ph_q;
  logic [5:0]  step_q;
  logic        init_done_q, busy_q, dirty_q;
  logic [7:0]  data_q;
  logic        rs_q, write_q, b8_q;
  logic [31:0] delay_q;
  logic [7:0]  cbuf_q [32];

  // Byte for the current step: init ROM or pass layout.
  logic [7:0]  nxt_data;
  logic        nxt_rs, nxt_8bit, last_step, start_pass;
  logic [31:0] nxt_delay;

  always_comb begin
    nxt_data  = 8'h00;
    nxt_rs    = 1'b0;
    nxt_8bit  = 1'b1;
    nxt_delay = 32'(DLY_CMD);
    last_step = 1'b0;
    if (mode_q == S_INIT) begin
      nxt_8bit  = (step_q >= 6'd4);
      last_step = (step_q == 6'd7);
      case (step_q[2:0])
        3'd0:    begin nxt_data = 8'h30; nxt_delay = 32'(DLY_PWRUP); end
        3'd1:    begin nxt_data = 8'h30; nxt_delay = 32'(DLY_NIB);   end
        3'd2:    begin nxt_data = 8'h30; nxt_delay = 32'(DLY_NIB);   end
        3'd3:    begin nxt_data = 8'h20; nxt_delay = 32'(DLY_NIB);   end
        3'd4:    nxt_data = 8'h28;
        3'd5:    nxt_data = 8'h06;
        3'd6:    nxt_data = 8'h0C;
        default: begin nxt_data = 8'h01; nxt_delay = 32'(DLY_CLR);   end
      endcase
    end else begin
      last_step = (step_q == 6'd33);
      if (step_q == 6'd0) begin
        nxt_data = 8'h80;
      end else if (step_q == 6'd17) begin
        nxt_data = 8'hC0;
      end else if (step_q <= 6'd16) begin
        nxt_rs   = 1'b1;
        nxt_data = cbuf_q[step_q[4:0] - 5'd1];
      end else begin
        // steps 18..33 -> buf[16..31]; 5-bit wrap maps 32,33 onto 30,31
        nxt_rs   = 1'b1;
        nxt_data = cbuf_q[step_q[4:0] - 5'd2];
      end
    end
  end

`ifdef LCD_SEQ_AUTO_REFRESH_EN
  logic [31:0] gap_q;
  assign start_pass = dirty_q || refresh || (gap_q >= 32'(REFRESH_GAP) - 32'd1);
`else
  assign start_pass = dirty_q || refresh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= S_INIT;
      ph_q        <= PH_ISSUE;
      step_q      <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      dirty_q     <= 1'b1;
      data_q      <= '0;
      rs_q        <= 1'b0;
      delay_q     <= '0;
      write_q     <= 1'b0;
      b8_q        <= 1'b0;
`ifdef LCD_SEQ_AUTO_REFRESH_EN
      gap_q       <= '0;
`endif
      for (int i = 0; i < 32; i++) cbuf_q[i] <= 8'h20;
    end else begin
      if (wr_en) begin
        cbuf_q[wr_addr] <= wr_data;
        dirty_q         <= 1'b1;
      end
      case (mode_q)
        S_IDLE: begin
          if (start_pass) begin
            mode_q <= S_PASS;
            ph_q   <= PH_ISSUE;
            step_q <= '0;
            busy_q <= 1'b1;
            // a write landing on the start cycle must still trigger a pass
            if (!wr_en) dirty_q <= 1'b0;
`ifdef LCD_SEQ_AUTO_REFRESH_EN
            gap_q  <= '0;
          end else begin
            gap_q  <= gap_q + 32'd1;
`endif
          end
        end
        default: begin
          case (ph_q)
            PH_ISSUE: if (lcd.if_ready) begin
              data_q  <= nxt_data;
              rs_q    <= nxt_rs;
              delay_q <= nxt_delay;
              b8_q    <= nxt_8bit;
              write_q <= 1'b1;
              ph_q    <= PH_ACCEPT;
            end
            PH_ACCEPT: if (!lcd.if_ready) begin
              write_q <= 1'b0;
              ph_q    <= PH_DONE;
            end
            default: if (lcd.if_ready) begin
              ph_q <= PH_ISSUE;
              if (last_step) begin
                if (mode_q == S_INIT) init_done_q <= 1'b1;
                mode_q <= S_IDLE;
                busy_q <= 1'b0;
              end else begin
                step_q <= step_q + 6'd1;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign init_done    = init_done_q;
  assign busy         = busy_q;
  assign lcd.if_data  = data_q;
  assign lcd.if_rs    = rs_q;
  assign lcd.if_delay = delay_q;
  assign lcd.if_write = write_q;
  assign lcd.if_8bit  = b8_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer -- directed bench for lcd_sequencer with a simple
// lcd_display ready model (ready low 3 cycles after if_write, high again
// 10 cycles after if_write drops). Delays scaled to 10/5/2/8.
module tb_lcd_sequencer;
  localparam int GAP = 300;

  logic       clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, refresh = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       init_done, busy;

  lcd_sequencer_if lcd();

  lcd_sequencer #(.DLY_PWRUP(10), .DLY_NIB(5), .DLY_CMD(2), .DLY_CLR(8),
                  .REFRESH_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .refresh(refresh), .init_done(init_done),
    .busy(busy), .lcd(lcd));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // lcd_display ready model
  logic rdy;
  int   rcnt;
  assign lcd.if_ready = rdy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b1; rcnt <= 0;
    end else if (rdy) begin
      if (lcd.if_write) begin
        if (rcnt == 2) begin rdy <= 1'b0; rcnt <= 0; end
        else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end else if (!lcd.if_write) begin
      if (rcnt == 9) begin rdy <= 1'b1; rcnt <= 0; end
      else rcnt <= rcnt + 1;
    end
  end

  typedef struct packed {
    logic [7:0]  d;
    logic        rs;
    logic        b8;
    logic [31:0] dly;
  } tx_t;

  tx_t txq[$];
  logic pw = 1'b0, pr = 1'b1, prst = 1'b0;
  tx_t  pb = '0;

  // Transaction capture on if_write rise; data must hold while write or !ready.
  always @(negedge clk) begin
    tx_t cur;
    cur = {lcd.if_data, lcd.if_rs, lcd.if_8bit, lcd.if_delay};
    if (rst_n && prst && (pw || !pr)) begin
      checks++;
      assert (cur === pb) else begin
        failures++;
        $error("FAIL hold_stable obs=%h exp=%h", cur, pb);
      end
    end
    if (rst_n && lcd.if_write && !pw) txq.push_back(cur);
    pw   = rst_n ? lcd.if_write : 1'b0;
    pr   = lcd.if_ready;
    prst = rst_n;
    pb   = cur;
  end

  logic [7:0] eb [32];

  function automatic tx_t mk(logic [7:0] d, logic rs, logic b8, logic [31:0] dly);
    return {d, rs, b8, dly};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input string tag, input tx_t exp);
    tx_t got;
    int  n = 0;
    while (txq.size() == 0 && n < 2000) begin @(negedge clk); n++; end
    if (txq.size() > 0) got = txq.pop_front();
    else got = 'x;
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    eb[a] = d;
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Expect pass bytes 0..nsteps-1; at step mid either write or pulse refresh.
  task automatic expect_pass(input string tag, input int mid, input logic mid_ref,
                             input logic [4:0] ma, input logic [7:0] md, input int nsteps);
    for (int s = 0; s < nsteps; s++) begin
      tx_t e;
      if (s == 0)       e = mk(8'h80, 1'b0, 1'b1, 32'd2);
      else if (s == 17) e = mk(8'hC0, 1'b0, 1'b1, 32'd2);
      else if (s <= 16) e = mk(eb[s-1], 1'b1, 1'b1, 32'd2);
      else              e = mk(eb[s-2], 1'b1, 1'b1, 32'd2);
      expect_tx($sformatf("%s_s%0d", tag, s), e);
      if (s == 0) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (s == mid) begin
        if (mid_ref) pulse_refresh();
        else wr(ma, md);
      end
    end
  endtask

  task automatic expect_init(input string tag);
    expect_tx({tag, "_0"}, mk(8'h30, 1'b0, 1'b0, 32'd10));
    expect_tx({tag, "_1"}, mk(8'h30, 1'b0, 1'b0, 32'd5));
    expect_tx({tag, "_2"}, mk(8'h30, 1'b0, 1'b0, 32'd5));
    expect_tx({tag, "_3"}, mk(8'h20, 1'b0, 1'b0, 32'd5));
    expect_tx({tag, "_4"}, mk(8'h28, 1'b0, 1'b1, 32'd2));
    expect_tx({tag, "_5"}, mk(8'h06, 1'b0, 1'b1, 32'd2));
    expect_tx({tag, "_6"}, mk(8'h0C, 1'b0, 1'b1, 32'd2));
    expect_tx({tag, "_7"}, mk(8'h01, 1'b0, 1'b1, 32'd8));
  endtask

  task automatic wait_idle(input string tag, input int quiet);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    repeat (quiet) @(negedge clk);
    chk({tag, "_noextra"}, 64'(txq.size()), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_write"}, 64'(lcd.if_write), 64'd0);
    chk({tag, "_outs"}, 64'({lcd.if_data, lcd.if_rs, lcd.if_8bit, lcd.if_delay}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) eb[i] = 8'h20;

    // 1: reset, init sequence, first pass of blanks
    #2 rst_n = 1'b0;
    #1 check_reset("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_init("init");
    expect_pass("p1", -1, 1'b0, 5'd0, 8'd0, 34);
    chk("init_done", 64'(init_done), 64'd1);

    // 2: writes land after the last byte of p1 was issued -> exactly one pass
    wr(5'd0, 8'h48);
    wr(5'd31, 8'h21);
    chk("p1_busy_tail", 64'(busy), 64'd1);
    expect_pass("p2", -1, 1'b0, 5'd0, 8'd0, 34);
    wait_idle("p2", 100);

    // 3: idle write starts a pass; write at step 10 forces a second pass
    wr(5'd1, 8'h42);
    expect_pass("p3a", 10, 1'b0, 5'd5, 8'h41, 34);
    expect_pass("p3b", -1, 1'b0, 5'd0, 8'd0, 34);
    wait_idle("p3", 100);

    // 5: refresh on clean buffer -> one pass; refresh mid-pass not queued
    pulse_refresh();
    expect_pass("p5", 5, 1'b1, 5'd0, 8'd0, 34);
    wait_idle("p5", 200);

    // 4: reset during step 20
    pulse_refresh();
    expect_pass("p4", -1, 1'b0, 5'd0, 8'd0, 21);
    chk("p4_pre_write", 64'(lcd.if_write), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    txq.delete();
    for (int i = 0; i < 32; i++) eb[i] = 8'h20;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_init("reinit");
    expect_pass("p4r", -1, 1'b0, 5'd0, 8'd0, 34);
    chk("reinit_done", 64'(init_done), 64'd1);

    // 6: auto refresh behaviour
`ifdef LCD_SEQ_AUTO_REFRESH_EN
    expect_pass("p6", -1, 1'b0, 5'd0, 8'd0, 34);
`else
    wait_idle("p6", 10000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
